// File: rtl/pal_color_encoder.sv
// PAL colour encoder: VIC-II palette index + sync/blank timing -> 6-bit luma and
// 1-bit chroma square wave, with subcarrier phase, V-switch and colour burst.
module pal_color_encoder #(
    parameter int unsigned BLANK_LEVEL = 16,
    parameter int unsigned LUMA_SCALE  = 3,
    parameter int unsigned BURST_DELAY = 128,
    parameter int unsigned BURST_LEN   = 320,
    parameter int unsigned BURST_HUE   = 12
) (
    input  logic       clk_142mhz,
    input  logic       reset_n,
    input  logic [3:0] pixel_color,
    input  logic       pixel_stb,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       blank,
    output logic [5:0] luma,
    output logic       color,
    output logic       burst_active
);

    localparam int unsigned PH_W    = 5;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned STEP_W  = 4;
    localparam int unsigned LUMA_W  = 6;
    localparam int unsigned CNT_MAX = (BURST_DELAY > BURST_LEN) ? BURST_DELAY : BURST_LEN;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_BURST = 2'd2
    } burst_state_e;

    typedef struct packed {
        logic [STEP_W-1:0] step;
        logic [PH_W-1:0]   hue;
        logic              chroma_en;
    } pal_entry_t;

    // VIC-II palette: luma step 0..8, hue in 11.25 degree steps, chroma enable
    function automatic pal_entry_t palette(input logic [IDX_W-1:0] idx);
        pal_entry_t e;
        e = '0;
        case (idx)
            4'd0:  e = {4'd0, 5'd0,  1'b0};
            4'd1:  e = {4'd8, 5'd0,  1'b0};
            4'd2:  e = {4'd2, 5'd10, 1'b1};
            4'd3:  e = {4'd6, 5'd26, 1'b1};
            4'd4:  e = {4'd3, 5'd4,  1'b1};
            4'd5:  e = {4'd5, 5'd20, 1'b1};
            4'd6:  e = {4'd1, 5'd0,  1'b1};
            4'd7:  e = {4'd7, 5'd16, 1'b1};
            4'd8:  e = {4'd3, 5'd12, 1'b1};
            4'd9:  e = {4'd1, 5'd14, 1'b1};
            4'd10: e = {4'd5, 5'd10, 1'b1};
            4'd11: e = {4'd2, 5'd0,  1'b0};
            4'd12: e = {4'd4, 5'd0,  1'b0};
            4'd13: e = {4'd7, 5'd20, 1'b1};
            4'd14: e = {4'd4, 5'd0,  1'b1};
            4'd15: e = {4'd6, 5'd0,  1'b0};
        endcase
        return e;
    endfunction

    // PAL line alternation mirrors the hue: (32 - hue) mod 32
    function automatic logic [PH_W-1:0] mirror(input logic [PH_W-1:0] hue, input logic vsw);
        return vsw ? (PH_W'(0) - hue) : hue;
    endfunction

    logic [PH_W-1:0]   phase_cnt_q;
    logic              vswitch_q, vswitch_d;
    logic              hsync_q, vsync_q;
    logic [IDX_W-1:0]  pix_q;
    burst_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              hs_rise, hs_fall, vs_rise;
    logic              burst_on_c;
    logic [IDX_W-1:0]  pix_idx_c;
    pal_entry_t        pal_c;
    logic [PH_W-1:0]   pix_p_c, burst_p_c;

    logic [STEP_W-1:0] step_s1_q;
    logic              pix_col_s1_q, burst_col_s1_q, burst_s1_q;
    logic              hs_s1_q, vs_s1_q, bl_s1_q;

    logic [LUMA_W-1:0] luma_d;
    logic              color_d, burst_active_d;

    assign hs_rise = hsync & ~hsync_q;
    assign hs_fall = ~hsync & hsync_q;
    assign vs_rise = vsync & ~vsync_q;

    // vsync rising edge has priority over the hsync toggle
    always_comb begin
        vswitch_d = vswitch_q;
        if (vs_rise) begin
            vswitch_d = 1'b0;
        end else if (hs_rise) begin
            vswitch_d = ~vswitch_q;
        end
    end

    // Burst FSM: state register
    always_ff @(posedge clk_142mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Burst FSM: next state; the fall cycle counts as the first delay clock
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (hs_rise || vsync) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (hs_fall) begin
            state_d = ST_DELAY;
            cnt_d   = CNT_W'(1);
        end else begin
            case (state_q)
                ST_DELAY: begin
                    if (cnt_q == CNT_W'(BURST_DELAY - 1)) begin
                        state_d = ST_BURST;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_BURST: begin
                    if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Burst FSM: outputs
    always_comb begin
        burst_on_c = 1'b0;
        if (state_q == ST_BURST) begin
            burst_on_c = 1'b1;
        end
    end

    // Stage 1 inputs: a strobed index bypasses the hold register
    always_comb begin
        pix_idx_c = pixel_stb ? pixel_color : pix_q;
        pal_c     = palette(pix_idx_c);
        pix_p_c   = phase_cnt_q + mirror(pal_c.hue, vswitch_q);
        burst_p_c = phase_cnt_q + mirror(PH_W'(BURST_HUE), vswitch_q);
    end

    always_ff @(posedge clk_142mhz or negedge reset_n) begin
        if (!reset_n) begin
            phase_cnt_q    <= '0;
            vswitch_q      <= 1'b0;
            hsync_q        <= 1'b0;
            vsync_q        <= 1'b0;
            pix_q          <= '0;
            step_s1_q      <= '0;
            pix_col_s1_q   <= 1'b0;
            burst_col_s1_q <= 1'b0;
            burst_s1_q     <= 1'b0;
            hs_s1_q        <= 1'b0;
            vs_s1_q        <= 1'b0;
            bl_s1_q        <= 1'b0;
        end else begin
            phase_cnt_q    <= phase_cnt_q + PH_W'(1);
            vswitch_q      <= vswitch_d;
            hsync_q        <= hsync;
            vsync_q        <= vsync;
            if (pixel_stb) begin
                pix_q <= pixel_color;
            end
            step_s1_q      <= pal_c.step;
            pix_col_s1_q   <= pal_c.chroma_en & ~pix_p_c[PH_W-1];
            burst_col_s1_q <= ~burst_p_c[PH_W-1];
            burst_s1_q     <= burst_on_c;
            hs_s1_q        <= hsync;
            vs_s1_q        <= vsync;
            bl_s1_q        <= blank;
        end
    end

    // Stage 2: output priority sync > burst > blank > pixel
    always_comb begin
        luma_d         = LUMA_W'(BLANK_LEVEL + LUMA_SCALE * 32'(step_s1_q));
        color_d        = pix_col_s1_q;
        burst_active_d = 1'b0;
        if (hs_s1_q || vs_s1_q) begin
            luma_d  = '0;
            color_d = 1'b0;
        end else if (burst_s1_q) begin
            luma_d         = LUMA_W'(BLANK_LEVEL);
            color_d        = burst_col_s1_q;
            burst_active_d = 1'b1;
        end else if (bl_s1_q) begin
            luma_d  = LUMA_W'(BLANK_LEVEL);
            color_d = 1'b0;
        end
    end

    always_ff @(posedge clk_142mhz or negedge reset_n) begin
        if (!reset_n) begin
            luma         <= '0;
            color        <= 1'b0;
            burst_active <= 1'b0;
        end else begin
            luma         <= luma_d;
            color        <= color_d;
            burst_active <= burst_active_d;
        end
    end

endmodule

// File: tb/tb_pal_color_encoder.sv
// Self-checking bench for pal_color_encoder: per-cycle expectations from an
// event-based line model are queued at drive time and popped two clocks later.
`timescale 1ns/1ps
module tb_pal_color_encoder;

    logic       clk;
    logic       reset_n;
    logic [3:0] pixel_color;
    logic       pixel_stb;
    logic       hsync;
    logic       vsync;
    logic       blank;
    logic [5:0] luma;
    logic       color;
    logic       burst_active;

    pal_color_encoder dut (
        .clk_142mhz   (clk),
        .reset_n      (reset_n),
        .pixel_color  (pixel_color),
        .pixel_stb    (pixel_stb),
        .hsync        (hsync),
        .vsync        (vsync),
        .blank        (blank),
        .luma         (luma),
        .color        (color),
        .burst_active (burst_active)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    typedef struct packed {
        logic [5:0] luma;
        logic       color;
        logic       burst;
    } exp_t;

    typedef struct {
        int luma;
        int hue;
        bit en;
    } pal_t;

    pal_t pal_tab[16];
    exp_t sb[$];

    int n_chk = 0;
    int n_err = 0;
    int burst_seen;

    // line model state
    int ph, vs_m, prev_h, prev_v, fall_cyc, cyc, pix_m;

    function automatic int mir(input int h);
        return (vs_m != 0) ? ((32 - h) % 32) : h;
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic model_reset();
        ph = 0; vs_m = 0; prev_h = 0; prev_v = 0; fall_cyc = -1; cyc = 0; pix_m = 0;
        sb.delete();
        sb.push_back(exp_t'{6'd16, 1'b0, 1'b0});
    endtask

    // one clock: predict, advance model, clock DUT, compare the entry now due
    task automatic tick();
        exp_t e, a;
        int   idx, dc;
        bit   bb;
        dc = cyc - fall_cyc;
        bb = (fall_cyc >= 0) && (dc >= 128) && (dc < 448);
        e  = '0;
        if (hsync || vsync) begin
            e = '0;
        end else if (bb) begin
            e.luma  = 6'd16;
            e.color = (((ph + mir(12)) % 32) < 16);
            e.burst = 1'b1;
        end else if (blank) begin
            e.luma = 6'd16;
        end else begin
            idx     = pixel_stb ? int'(pixel_color) : pix_m;
            e.luma  = 6'(pal_tab[idx].luma);
            e.color = pal_tab[idx].en && (((ph + mir(pal_tab[idx].hue)) % 32) < 16);
        end
        sb.push_back(e);
        if (pixel_stb) pix_m = int'(pixel_color);
        if ((hsync && !prev_h) || vsync) fall_cyc = -1;
        else if (!hsync && prev_h) fall_cyc = cyc;
        if (vsync && !prev_v) vs_m = 0;
        else if (hsync && !prev_h) vs_m = (vs_m != 0) ? 0 : 1;
        prev_h = int'(hsync);
        prev_v = int'(vsync);
        ph     = (ph + 1) % 32;
        cyc++;
        @(posedge clk);
        #1;
        if (burst_active) burst_seen++;
        a = sb.pop_front();
        e = a;
        a = {luma, color, burst_active};
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL sb cyc=%0d: got luma=%0d color=%0b burst=%0b, want luma=%0d color=%0b burst=%0b",
                     cyc, a.luma, a.color, a.burst, e.luma, e.color, e.burst);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        hsync = 1'b0; vsync = 1'b0; blank = 1'b1; pixel_stb = 1'b0; pixel_color = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_luma", int'(luma), 0);
        chk("rst_color", int'(color), 0);
        chk("rst_burst", int'(burst_active), 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic hs_pulse(input int hi, input int lo);
        hsync = 1'b1;
        run(hi);
        hsync = 1'b0;
        run(lo);
    endtask

    initial begin
        pal_tab[0]  = '{16, 0,  1'b0}; pal_tab[1]  = '{40, 0,  1'b0};
        pal_tab[2]  = '{22, 10, 1'b1}; pal_tab[3]  = '{34, 26, 1'b1};
        pal_tab[4]  = '{25, 4,  1'b1}; pal_tab[5]  = '{31, 20, 1'b1};
        pal_tab[6]  = '{19, 0,  1'b1}; pal_tab[7]  = '{37, 16, 1'b1};
        pal_tab[8]  = '{25, 12, 1'b1}; pal_tab[9]  = '{19, 14, 1'b1};
        pal_tab[10] = '{31, 10, 1'b1}; pal_tab[11] = '{22, 0,  1'b0};
        pal_tab[12] = '{28, 0,  1'b0}; pal_tab[13] = '{37, 20, 1'b1};
        pal_tab[14] = '{28, 0,  1'b1}; pal_tab[15] = '{34, 0,  1'b0};

        // reset, blanked idle line
        do_reset();
        run(40);

        // every palette entry: one strobe, then hold with a changed index on the bus
        blank = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pixel_color = 4'(i);
            pixel_stb   = 1'b1;
            tick();
            pixel_stb   = 1'b0;
            pixel_color = 4'((i + 5) % 16);
            run(40);
        end

        // long hsync then a full burst on a blanked line
        blank = 1'b1;
        burst_seen = 0;
        hs_pulse(700, 600);
        chk("burst_len_line1", burst_seen, 320);

        // second line: mirrored burst, then red pixels on the visible part
        burst_seen = 0;
        hs_pulse(200, 500);
        chk("burst_len_line2", burst_seen, 320);
        blank = 1'b0; pixel_color = 4'd2; pixel_stb = 1'b1;
        tick();
        pixel_stb = 1'b0;
        run(64);
        vsync = 1'b1;
        run(10);
        vsync = 1'b0;
        run(64);
        blank = 1'b1;

        // hsync rising mid-burst aborts, next fall starts a new burst
        hs_pulse(50, 200);
        hs_pulse(20, 500);

        // vsync during the delay window cancels the burst
        burst_seen = 0;
        hs_pulse(50, 60);
        vsync = 1'b1;
        run(5);
        vsync = 1'b0;
        run(500);
        chk("burst_vsync_abort", burst_seen, 0);

        // asynchronous reset in the middle of a burst
        hs_pulse(50, 200);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_luma", int'(luma), 0);
        chk("async_color", int'(color), 0);
        chk("async_burst", int'(burst_active), 0);
        do_reset();
        burst_seen = 0;
        run(600);
        chk("no_burst_after_reset", burst_seen, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
